// File: rtl/mesh_port_arbiter.sv
// rtl/mesh_port_arbiter.sv - round-robin arbiter feeding one mesh output link from queued requesters
//
// Purpose: picks one requester FIFO head at a time (round-robin from rr_ptr),
// pops it with a one-cycle pulse, and holds the packet in a register that is
// offered downstream with the same pndng/pop handshake.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   pndng_in   in   [NUM_REQ]          requester i has a packet at its FIFO head
//   data_in    in   [NUM_REQ*pckg_sz]  requester i head at [i*pckg_sz +: pckg_sz]
//   pop        out  [NUM_REQ]          one-hot, one-cycle dequeue pulse
//   pndng_out  out                     holding register valid
//   data_out   out  [pckg_sz]          holding register contents
//   popin      in                      downstream consumed data_out this cycle
//   grant_id   out  [clog2(NUM_REQ)]   requester owning the held packet
//   busy       out                     high while a packet is held
//   pkt_cnt    out  [CNT_W]            packets delivered, wraps
module mesh_port_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int pckg_sz = 20,
   parameter int CNT_W   = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           pndng_in,
   input  logic [NUM_REQ*pckg_sz-1:0]   data_in,
   output logic [NUM_REQ-1:0]           pop,
   output logic                         pndng_out,
   output logic [pckg_sz-1:0]           data_out,
   input  logic                         popin,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         busy,
   output logic [CNT_W-1:0]             pkt_cnt
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int PW    = IDX_W + 1;
   localparam logic [PW-1:0]    NREQ = PW'(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     rr_ptr, rr_nxt;
   logic [IDX_W-1:0]     g;
   logic                 found;
   logic [PW-1:0]        idx;

   logic [NUM_REQ-1:0]   pop_nxt;
   logic                 pndng_nxt;
   logic [pckg_sz-1:0]   data_nxt;
   logic [IDX_W-1:0]     grant_nxt;
   logic                 busy_nxt;
   logic [CNT_W-1:0]     cnt_nxt;

   // Rotating priority search. idx carries one extra bit so rr_ptr+k can be
   // folded back below NUM_REQ even when NUM_REQ is not a power of two.
   always_comb begin
      found = 1'b0;
      g     = '0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, rr_ptr} + PW'(k);
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && pndng_in[idx[IDX_W-1:0]]) begin
            found = 1'b1;
            g     = idx[IDX_W-1:0];
         end
      end
   end

   // State register and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         pop       <= '0;
         pndng_out <= 1'b0;
         data_out  <= '0;
         grant_id  <= '0;
         busy      <= 1'b0;
         pkt_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_nxt;
         pop       <= pop_nxt;
         pndng_out <= pndng_nxt;
         data_out  <= data_nxt;
         grant_id  <= grant_nxt;
         busy      <= busy_nxt;
         pkt_cnt   <= cnt_nxt;
      end
   end

   // Next state. HOLD always returns through IDLE so the popped source's
   // pndng_in has settled before it can be sampled again.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = HOLD;
         HOLD:    if (popin) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the output registers
   always_comb begin
      rr_nxt    = rr_ptr;
      pop_nxt   = '0;
      pndng_nxt = pndng_out;
      data_nxt  = data_out;
      grant_nxt = grant_id;
      busy_nxt  = busy;
      cnt_nxt   = pkt_cnt;
      case (state)
         IDLE: begin
            if (found) begin
               pop_nxt   = NUM_REQ'(1) << g;
               data_nxt  = data_in[g*pckg_sz +: pckg_sz];
               grant_nxt = g;
               pndng_nxt = 1'b1;
               busy_nxt  = 1'b1;
               rr_nxt    = (g == LAST) ? '0 : g + 1'b1;
            end
         end
         HOLD: begin
            if (popin) begin
               pndng_nxt = 1'b0;
               busy_nxt  = 1'b0;
               cnt_nxt   = pkt_cnt + 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// tb/tb_mesh_port_arbiter.sv - directed self-checking bench for mesh_port_arbiter
module tb_mesh_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  pndng_in;
   logic [79:0] data_in;
   logic [3:0]  pop;
   logic        pndng_out;
   logic [19:0] data_out;
   logic        popin;
   logic [1:0]  grant_id;
   logic        busy;
   logic [15:0] pkt_cnt;

   logic [19:0] lane [4];
   int tests = 0;
   int fails = 0;
   int exp_cnt = 0;

   assign data_in = {lane[3], lane[2], lane[1], lane[0]};

   always #5 clk = ~clk;

   mesh_port_arbiter #(.NUM_REQ(4), .pckg_sz(20), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .pndng_in(pndng_in), .data_in(data_in),
      .pop(pop), .pndng_out(pndng_out), .data_out(data_out), .popin(popin),
      .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Expected state right after a grant to requester e
   task automatic check_grant(input string tag, input int e);
      logic [3:0] oh;
      oh = 4'b0001 << e;
      check({tag, " pop"},   32'(pop), 32'(oh));
      check({tag, " gid"},   32'(grant_id), 32'(e));
      check({tag, " data"},  32'(data_out), 32'(lane[e]));
      check({tag, " pndng"}, 32'(pndng_out), 32'd1);
      check({tag, " busy"},  32'(busy), 32'd1);
   endtask

   task automatic check_idle(input string tag);
      check({tag, " pop"},   32'(pop), 32'd0);
      check({tag, " pndng"}, 32'(pndng_out), 32'd0);
      check({tag, " busy"},  32'(busy), 32'd0);
      check({tag, " cnt"},   32'(pkt_cnt), 32'(exp_cnt));
   endtask

   initial begin
      lane[0] = 20'h11111;
      lane[1] = 20'h22222;
      lane[2] = 20'h0A5A5;
      lane[3] = 20'h33333;
      reset = 1'b0;
      pndng_in = '0;
      popin = 1'b0;

      // reset held with random activity
      for (int i = 0; i < 6; i++) begin
         pndng_in = 4'($urandom);
         popin = 1'($urandom);
         step();
         check("rst pop",   32'(pop), 32'd0);
         check("rst pndng", 32'(pndng_out), 32'd0);
         check("rst data",  32'(data_out), 32'd0);
         check("rst gid",   32'(grant_id), 32'd0);
         check("rst busy",  32'(busy), 32'd0);
         check("rst cnt",   32'(pkt_cnt), 32'd0);
      end
      pndng_in = '0;
      popin = 1'b0;
      reset = 1'b1;
      step();
      check_idle("idle0");

      // single request from requester 2
      pndng_in = 4'b0100;
      step();
      check_grant("single", 2);
      pndng_in = 4'b0000;
      step();
      check("single pop off", 32'(pop), 32'd0);
      check("single hold",    32'(pndng_out), 32'd1);
      step();
      popin = 1'b1;
      step();
      popin = 1'b0;
      exp_cnt = 1;
      check_idle("single done");
      check("single data kept", 32'(data_out), 32'(lane[2]));

      // popin while idle must not count
      popin = 1'b1;
      step();
      popin = 1'b0;
      check_idle("idle popin");

      // backpressure: rr_ptr=3 so requester 3 wins
      pndng_in = 4'b1111;
      step();
      check_grant("bp grant", 3);
      for (int i = 0; i < 10; i++) begin
         pndng_in = 4'($urandom);
         step();
         check("bp pop",   32'(pop), 32'd0);
         check("bp pndng", 32'(pndng_out), 32'd1);
         check("bp gid",   32'(grant_id), 32'd3);
         check("bp data",  32'(data_out), 32'(lane[3]));
         check("bp cnt",   32'(pkt_cnt), 32'(exp_cnt));
      end
      pndng_in = '0;
      popin = 1'b1;
      step();
      popin = 1'b0;
      exp_cnt++;
      check_idle("bp done");

      // fairness: all requesting, popin tied high, rr_ptr=0
      pndng_in = 4'b1111;
      popin = 1'b1;
      for (int n = 0; n < 6; n++) begin
         step();
         check_grant("fair", n % 4);
         step();
         exp_cnt++;
         check_idle("fair gap");
      end
      pndng_in = '0;
      popin = 1'b0;
      step();

      // pointer skip: serve 0 -> rr_ptr=1, then 1001 -> 3, then 0
      pndng_in = 4'b0001;
      step();
      check_grant("skip g0", 0);
      pndng_in = 4'b1001;
      popin = 1'b1;
      step();
      exp_cnt++;
      popin = 1'b0;
      step();
      check_grant("skip g3", 3);
      popin = 1'b1;
      step();
      exp_cnt++;
      popin = 1'b0;
      step();
      check_grant("skip g0b", 0);
      popin = 1'b1;
      step();
      exp_cnt++;
      popin = 1'b0;
      pndng_in = 4'b0000;
      check_idle("skip done");

      // mid-HOLD async reset
      pndng_in = 4'b0100;
      step();
      check_grant("mid grant", 2);
      #2 reset = 1'b0;
      #1;
      check("mid rst pndng", 32'(pndng_out), 32'd0);
      check("mid rst busy",  32'(busy), 32'd0);
      check("mid rst data",  32'(data_out), 32'd0);
      check("mid rst gid",   32'(grant_id), 32'd0);
      check("mid rst cnt",   32'(pkt_cnt), 32'd0);
      step();
      pndng_in = 4'b0110;
      reset = 1'b1;
      step();
      check_grant("post rst", 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
